register_port_sequencer: RTL and testbench

//  CPU-side initiator for the 256x8 register RAM (sync read, 1-cycle read latency, read-before-write).

---
 rtl/regseq_pkg.sv | 26 ++
 rtl/register_port_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_register_port_sequencer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regseq_pkg.sv
// Shared types and helpers for the register port sequencer: FSM state encoding,
// byte-select constants and the register RAM address builder.
package regseq_pkg;

  localparam int REG_BANK_W = 4;
  localparam int REG_IDX_W  = 3;

  localparam logic HI_BYTE = 1'b0;
  localparam logic LO_BYTE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE_LO = 3'd1,
    ST_CAP_HI   = 3'd2,
    ST_CAP_LO   = 3'd3,
    ST_CLEAR    = 3'd4
  } state_e;

  // Big-endian layout: the high byte of a word sits at the even address.
  function automatic logic [7:0] reg_addr(input logic [REG_BANK_W-1:0] bank,
                                          input logic [REG_IDX_W-1:0]  rg,
                                          input logic                  byte_sel);
    return {bank, rg, byte_sel};
  endfunction

endpackage

// File: rtl/register_port_sequencer.sv
// CPU-side initiator for the 256x8 register RAM: turns word/byte register requests into
// sequenced byte accesses. Optional post-reset clear sweep enabled by REGSEQ_CLEAR_EN.
//
// state       | meaning
// ------------+------------------------------------------------------------------
// ST_IDLE     | waiting for a request; first RAM access is driven on the accept edge
// ST_ISSUE_LO | word access: drive the low-byte address (and data for writes)
// ST_CAP_HI   | capture high byte of a word read; pass-through for byte reads
// ST_CAP_LO   | final cycle: capture low/byte read data, pulse rsp_valid
// ST_CLEAR    | post-reset sweep writing CLR_VAL to every address (macro only)
module register_port_sequencer
  import regseq_pkg::*;
#(
  parameter int BANK_W = REG_BANK_W
`ifdef REGSEQ_CLEAR_EN
  ,
  parameter logic [7:0] CLR_VAL = 8'h00
`endif
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_word,
  input  logic              req_lo,
  input  logic [BANK_W-1:0] req_bank,
  input  logic [2:0]        req_reg,
  input  logic [15:0]       req_wdata,
  output logic              rsp_valid,
  output logic [15:0]       rsp_rdata,
  output logic              init_done,
  output logic              ram_write_en,
  output logic [7:0]        ram_address,
  output logic [7:0]        ram_data_in,
  input  logic [7:0]        ram_data_out
);

  state_e      state_q, state_d;
  logic        ready_q, ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_rdata_q, rsp_rdata_d;
  logic        ram_we_q, ram_we_d;
  logic [7:0]  ram_addr_q, ram_addr_d;
  logic [7:0]  ram_din_q, ram_din_d;
  logic        op_write_q, op_write_d;
  logic        op_word_q, op_word_d;
  logic [7:0]  wdata_lo_q, wdata_lo_d;
  logic [7:0]  data_hi_q, data_hi_d;
  logic        init_d;
  logic        accept;

`ifdef REGSEQ_CLEAR_EN
  logic [7:0]  clr_cnt_q, clr_cnt_d;
  logic        init_done_q, init_done_d;
  localparam state_e RESET_STATE = ST_CLEAR;
`else
  localparam state_e RESET_STATE = ST_IDLE;
`endif

  // ready is registered so it reads 0 right after reset until the first edge
  assign accept = req_valid & ready_q;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 16'h0000;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= 8'h00;
      ram_din_q   <= 8'h00;
      op_write_q  <= 1'b0;
      op_word_q   <= 1'b0;
      wdata_lo_q  <= 8'h00;
      data_hi_q   <= 8'h00;
`ifdef REGSEQ_CLEAR_EN
      clr_cnt_q   <= 8'h00;
      init_done_q <= 1'b0;
`endif
    end else begin
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      op_write_q  <= op_write_d;
      op_word_q   <= op_word_d;
      wdata_lo_q  <= wdata_lo_d;
      data_hi_q   <= data_hi_d;
`ifdef REGSEQ_CLEAR_EN
      clr_cnt_q   <= clr_cnt_d;
      init_done_q <= init_done_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_word)       state_d = ST_ISSUE_LO;
          else if (req_write) state_d = ST_CAP_LO;
          else                state_d = ST_CAP_HI;
        end
      end
      ST_ISSUE_LO: state_d = op_write_q ? ST_CAP_LO : ST_CAP_HI;
      ST_CAP_HI:   state_d = ST_CAP_LO;
      ST_CAP_LO:   state_d = ST_IDLE;
`ifdef REGSEQ_CLEAR_EN
      ST_CLEAR: begin
        if (clr_cnt_q == 8'hFF) state_d = ST_IDLE;
      end
`endif
      default:     state_d = ST_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    op_write_d  = op_write_q;
    op_word_d   = op_word_q;
    wdata_lo_d  = wdata_lo_q;
    data_hi_d   = data_hi_q;
`ifdef REGSEQ_CLEAR_EN
    clr_cnt_d   = clr_cnt_q;
    init_done_d = init_done_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          ram_addr_d = reg_addr(req_bank, req_reg, req_word ? HI_BYTE : req_lo);
          ram_we_d   = req_write;
          ram_din_d  = req_word ? req_wdata[15:8] : req_wdata[7:0];
          op_write_d = req_write;
          op_word_d  = req_word;
          wdata_lo_d = req_wdata[7:0];
        end
      end
      ST_ISSUE_LO: begin
        ram_addr_d = {ram_addr_q[7:1], LO_BYTE};
        ram_we_d   = op_write_q;
        ram_din_d  = wdata_lo_q;
      end
      // A byte read passes through here while the RAM output is still stale.
      ST_CAP_HI: begin
        if (op_word_q) data_hi_d = ram_data_out;
      end
      ST_CAP_LO: begin
        rsp_valid_d = 1'b1;
        if (!op_write_q) begin
          rsp_rdata_d = op_word_q ? {data_hi_q, ram_data_out} : {8'h00, ram_data_out};
        end
      end
`ifdef REGSEQ_CLEAR_EN
      ST_CLEAR: begin
        ram_we_d   = 1'b1;
        ram_addr_d = clr_cnt_q;
        ram_din_d  = CLR_VAL;
        if (clr_cnt_q != 8'hFF) clr_cnt_d = clr_cnt_q + 8'd1;
        else                    init_done_d = 1'b1;
      end
`endif
      default: ;
    endcase
  end

`ifdef REGSEQ_CLEAR_EN
  assign init_d    = init_done_d;
  assign init_done = init_done_q;
`else
  assign init_d    = 1'b1;
  assign init_done = 1'b1;
`endif

  assign ready_d      = (state_d == ST_IDLE) & init_d;
  assign req_ready    = ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign ram_write_en = ram_we_q;
  assign ram_address  = ram_addr_q;
  assign ram_data_in  = ram_din_q;

endmodule

// File: tb/tb_register_port_sequencer.sv
// Scoreboard bench for register_port_sequencer driving a behavioural 256x8 register RAM
// (sync read, read-before-write, power-up 0xFE). Honours REGSEQ_CLEAR_EN when defined.
module tb_register_port_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic        req_word = 1'b0;
  logic        req_lo = 1'b0;
  logic [3:0]  req_bank = 4'h0;
  logic [2:0]  req_reg = 3'h0;
  logic [15:0] req_wdata = 16'h0000;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        init_done;
  logic        ram_write_en;
  logic [7:0]  ram_address;
  logic [7:0]  ram_data_in;
  logic [7:0]  ram_data_out;

`ifdef REGSEQ_CLEAR_EN
  localparam logic [7:0] FILL = 8'h00;
  localparam logic       INIT_AT_RESET = 1'b0;
`else
  localparam logic [7:0] FILL = 8'hFE;
  localparam logic       INIT_AT_RESET = 1'b1;
`endif

  typedef struct {
    logic [15:0] rdata;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] last_rdata = 16'h0000;
  logic [7:0]  mem [256];

  register_port_sequencer dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_word    (req_word),
    .req_lo      (req_lo),
    .req_bank    (req_bank),
    .req_reg     (req_reg),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .init_done   (init_done),
    .ram_write_en(ram_write_en),
    .ram_address (ram_address),
    .ram_data_in (ram_data_in),
    .ram_data_out(ram_data_out)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'hFE;
    ram_data_out = 8'h00;
  end

  always @(posedge clock) begin
    if (ram_write_en) mem[ram_address] <= ram_data_in;
    ram_data_out <= mem[ram_address];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every response must match the oldest expectation, on the expected cycle.
  always @(negedge clock) begin
    if (rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_rsp: got rsp_valid with rdata %0h expected none", rsp_rdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_rdata", {16'h0, rsp_rdata}, {16'h0, e.rdata});
        chk("rsp_cycle", cyc, e.due);
      end
    end
  end

  task automatic do_req(input logic wr, input logic word, input logic lo,
                        input logic [3:0] bank, input logic [2:0] rg, input logic [15:0] wd,
                        input logic expect_rsp, input logic [15:0] exp_rd, input int lat,
                        output int t_acc);
    int guard;
    guard = 0;
    @(negedge clock);
    while (req_ready !== 1'b1 && guard < 600) begin
      @(negedge clock);
      guard++;
    end
    if (req_ready !== 1'b1) begin
      chk("ready_timeout", {31'h0, req_ready}, 32'h1);
      t_acc = -1;
      return;
    end
    req_write = wr;
    req_word  = word;
    req_lo    = lo;
    req_bank  = bank;
    req_reg   = rg;
    req_wdata = wd;
    req_valid = 1'b1;
    t_acc = cyc + 1;
    if (expect_rsp) begin
      exp_t e;
      e.rdata = wr ? last_rdata : exp_rd;
      e.due   = t_acc + lat;
      sb.push_back(e);
      if (!wr) last_rdata = exp_rd;
    end
    @(posedge clock);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((sb.size() != 0 || req_ready !== 1'b1) && guard < 600) begin
      @(negedge clock);
      guard++;
    end
    if (sb.size() != 0) chk("idle_timeout", sb.size(), 0);
  endtask

  initial begin
    int t_w, t_r, t0;
    #(2_000_000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_w, t_r, t0;
    #2;
    chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rsp_rdata", {16'h0, rsp_rdata}, 32'h0);
    chk("rst_ram_we", {31'h0, ram_write_en}, 32'h0);
    chk("rst_ram_addr", {24'h0, ram_address}, 32'h0);
    chk("rst_ram_din", {24'h0, ram_data_in}, 32'h0);
    chk("rst_init_done", {31'h0, init_done}, {31'h0, INIT_AT_RESET});

    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    t0 = cyc;
    #1 chk("ready_before_edge", {31'h0, req_ready}, 32'h0);

`ifdef REGSEQ_CLEAR_EN
    // Hold a write request through the sweep; it must never be taken.
    req_write = 1'b1; req_word = 1'b1; req_lo = 1'b0;
    req_bank = 4'd2; req_reg = 3'd5; req_wdata = 16'hFFFF;
    req_valid = 1'b1;
    begin
      int guard;
      guard = 0;
      @(negedge clock);
      while (init_done !== 1'b1 && guard < 400) begin
        @(negedge clock);
        guard++;
      end
    end
    req_valid = 1'b0;
    chk("init_done_cycles", cyc - t0, 256);
    repeat (3) @(negedge clock);
    chk("sweep_no_accept_2a", {24'h0, mem[8'h2A]}, 32'h00);
    chk("sweep_fill_00", {24'h0, mem[8'h00]}, 32'h00);
    chk("sweep_fill_ff", {24'h0, mem[8'hFF]}, 32'h00);
    do_req(1'b0, 1'b1, 1'b0, 4'd9, 3'd3, 16'h0, 1'b1, 16'h0000, 3, t_r);
`else
    @(posedge clock);
    #1 chk("ready_after_edge", {31'h0, req_ready}, 32'h1);
`endif

    // Word write then word read of bank 2 reg 5
    do_req(1'b1, 1'b1, 1'b0, 4'd2, 3'd5, 16'hBEEF, 1'b1, 16'h0, 2, t_w);
    wait_idle();
    chk("mem_2a", {24'h0, mem[8'h2A]}, 32'hBE);
    chk("mem_2b", {24'h0, mem[8'h2B]}, 32'hEF);

    do_req(1'b0, 1'b1, 1'b0, 4'd2, 3'd5, 16'h0, 1'b1, 16'hBEEF, 3, t_r);
    chk("busy_ready_T", {31'h0, req_ready}, 32'h0);
    @(posedge clock); #1 chk("busy_ready_T1", {31'h0, req_ready}, 32'h0);
    @(posedge clock); #1 chk("busy_ready_T2", {31'h0, req_ready}, 32'h0);
    @(posedge clock); #1 chk("ready_T3", {31'h0, req_ready}, 32'h1);
    wait_idle();

    // Byte write / read at the top address
    do_req(1'b1, 1'b0, 1'b1, 4'd15, 3'd7, 16'h335A, 1'b1, 16'h0, 1, t_w);
    wait_idle();
    chk("mem_ff", {24'h0, mem[8'hFF]}, 32'h5A);
    chk("mem_fe_untouched", {24'h0, mem[8'hFE]}, {24'h0, FILL});
    do_req(1'b0, 1'b0, 1'b1, 4'd15, 3'd7, 16'h0, 1'b1, 16'h005A, 2, t_r);
    do_req(1'b0, 1'b0, 1'b0, 4'd2, 3'd5, 16'h0, 1'b1, 16'h00BE, 2, t_r);
    wait_idle();

    // Back-to-back: read issued on the write's response cycle
    do_req(1'b1, 1'b1, 1'b0, 4'd3, 3'd1, 16'hC0DE, 1'b1, 16'h0, 2, t_w);
    do_req(1'b0, 1'b1, 1'b0, 4'd3, 3'd1, 16'h0, 1'b1, 16'hC0DE, 3, t_r);
    chk("b2b_gap", t_r - t_w, 3);
    wait_idle();

    // Reset between T+1 and T+2 of a word write to 0x10
    do_req(1'b1, 1'b1, 1'b0, 4'd1, 3'd0, 16'h1234, 1'b0, 16'h0, 0, t_w);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1 chk("abort_we_low", {31'h0, ram_write_en}, 32'h0);
    chk("abort_rdata_reset", {16'h0, rsp_rdata}, {16'h0, 16'hC0DE} & 32'h0);
    @(negedge clock);
    @(negedge clock);
    chk("abort_mem_10", {24'h0, mem[8'h10]}, 32'h12);
    chk("abort_mem_11", {24'h0, mem[8'h11]}, {24'h0, FILL});
    last_rdata = 16'h0000;
    reset_n = 1'b1;

`ifdef REGSEQ_CLEAR_EN
    do_req(1'b0, 1'b1, 1'b0, 4'd1, 3'd0, 16'h0, 1'b1, 16'h0000, 3, t_r);
`else
    do_req(1'b0, 1'b1, 1'b0, 4'd1, 3'd0, 16'h0, 1'b1, 16'h12FE, 3, t_r);
`endif
    wait_idle();
    repeat (3) @(negedge clock);
    chk("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
